// File: rtl/sd_block_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sd_block_writer
// Purpose  : DAT0 transmit engine for single-block SD writes (CMD24 data
//            phase), 1-bit bus, 512-byte sector. Streams start bit, 4096
//            data bits, CRC16 and end bit onto DAT0, then releases the line,
//            collects the CRC-status token and waits out card busy.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PRE_CYCLES    sdclk periods DAT0 is driven high before the start bit
//   TOK_TIMEOUT   sdclk rising edges allowed from release to token start bit
//   BUSY_TIMEOUT  sdclk rising edges allowed for busy to end after the token
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   sdclk                 SD clock owned by the command controller
//   wstart                1-clk pulse starting a block transfer
//   wbusy, wdone          transfer in progress / 1-clk completion pulse
//   wstatus, wtimeout     token bits (3'b111 on token timeout), timeout flag
//   inreq, inaddr, inbyte sector buffer fetch (data returns 1 clk later)
//   sddat0_out/_oe/_in    DAT0 pad drive, enable and sampled value
//   SD_D0_DIR             level-shifter direction, mirrors sddat0_oe
// Build option
//   SDWR_STATS_EN  adds wr_ok_cnt / wr_fail_cnt completion counters
// ============================================================================
module sd_block_writer #(
  parameter int PRE_CYCLES   = 2,
  parameter int TOK_TIMEOUT  = 64,
  parameter int BUSY_TIMEOUT = 4000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdclk,
  input  logic       wstart,
  output logic       wbusy,
  output logic       wdone,
  output logic [2:0] wstatus,
  output logic       wtimeout,
  output logic       inreq,
  output logic [8:0] inaddr,
  input  logic [7:0] inbyte,
  output logic       sddat0_out,
  output logic       sddat0_oe,
  input  logic       sddat0_in,
  output logic       SD_D0_DIR
`ifdef SDWR_STATS_EN
  ,
  output logic [15:0] wr_ok_cnt,
  output logic [15:0] wr_fail_cnt
`endif
);

  // One shared counter serves the preamble, CRC, token and both timeouts.
  localparam int MAX_A = (BUSY_TIMEOUT > TOK_TIMEOUT) ? BUSY_TIMEOUT : TOK_TIMEOUT;
  localparam int MAX_T = (MAX_A > PRE_CYCLES) ? MAX_A : PRE_CYCLES;
  localparam int CNT_W = $clog2(MAX_T + 2);

  localparam logic [CNT_W-1:0] PRE_LIM  = CNT_W'(PRE_CYCLES);
  localparam logic [CNT_W-1:0] TOK_LIM  = CNT_W'(TOK_TIMEOUT);
  localparam logic [CNT_W-1:0] BUSY_LIM = CNT_W'(BUSY_TIMEOUT);
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0] TOK_BITS = CNT_W'(3);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_PRE     = 4'd1,
    S_START   = 4'd2,
    S_DATA    = 4'd3,
    S_CRC     = 4'd4,
    S_ENDB    = 4'd5,
    S_TOKWAIT = 4'd6,
    S_TOK     = 4'd7,
    S_BUSY    = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  state_t           state;
  logic             sdclk_q;
  logic             req_q;
  logic [7:0]       pf;        // prefetched next byte
  logic [7:0]       sh;        // byte being shifted out, MSB at bit 7
  logic [11:0]      idx;       // index of the data bit currently on DAT0
  logic [15:0]      crc;
  logic [CNT_W-1:0] cnt;

  logic             sd_rise;
  logic             sd_fall;
  logic [11:0]      idx_inc;
  logic             new_byte;
  logic             next_bit;
  logic [7:0]       next_sh;
  logic [8:0]       next_byte;
  logic [8:0]       next_addr;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign sd_rise   = sdclk & ~sdclk_q;
  assign sd_fall   = ~sdclk & sdclk_q;
  assign idx_inc   = idx + 12'd1;
  assign new_byte  = (idx_inc[2:0] == 3'd0);
  // Byte boundary: take the next bit from the prefetch register.
  assign next_bit  = new_byte ? pf[7] : sh[7];
  assign next_sh   = new_byte ? {pf[6:0], 1'b0} : {sh[6:0], 1'b0};
  assign next_byte = idx_inc[11:3];
  assign next_addr = next_byte + 9'd1;
  assign cnt_inc   = cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  assign SD_D0_DIR = sddat0_oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sdclk_q    <= 1'b0;
      req_q      <= 1'b0;
      pf         <= 8'h00;
      sh         <= 8'h00;
      idx        <= 12'd0;
      crc        <= 16'h0000;
      cnt        <= '0;
      wbusy      <= 1'b0;
      wdone      <= 1'b0;
      wstatus    <= 3'b000;
      wtimeout   <= 1'b0;
      inreq      <= 1'b0;
      inaddr     <= 9'd0;
      sddat0_out <= 1'b1;
      sddat0_oe  <= 1'b0;
    end else begin
      sdclk_q <= sdclk;
      inreq   <= 1'b0;
      // Buffer data is valid exactly one clk after the fetch strobe.
      req_q   <= inreq;
      if (req_q) begin
        pf <= inbyte;
      end

      case (state)
        S_IDLE: begin
          sddat0_oe  <= 1'b0;
          sddat0_out <= 1'b1;
          if (wdone) begin
            // wbusy drops the clk after wdone; a wstart here is ignored.
            wdone <= 1'b0;
            wbusy <= 1'b0;
          end else if (wstart) begin
            wbusy    <= 1'b1;
            wstatus  <= 3'b000;
            wtimeout <= 1'b0;
            inreq    <= 1'b1;
            inaddr   <= 9'd0;
            cnt      <= '0;
            state    <= S_PRE;
          end
        end

        S_PRE: begin
          if (sd_fall) begin
            if (cnt == PRE_LIM) begin
              sddat0_out <= 1'b0;
              crc        <= 16'h0000;
              state      <= S_START;
            end else begin
              sddat0_oe  <= 1'b1;
              sddat0_out <= 1'b1;
              cnt        <= cnt_inc;
            end
          end
        end

        S_START: begin
          if (sd_fall) begin
            sddat0_out <= pf[7];
            sh         <= {pf[6:0], 1'b0};
            crc        <= crc_step(crc, pf[7]);
            idx        <= 12'd0;
            inreq      <= 1'b1;
            inaddr     <= 9'd1;
            state      <= S_DATA;
          end
        end

        S_DATA: begin
          if (sd_fall) begin
            if (idx == 12'd4095) begin
              sddat0_out <= crc[15];
              crc        <= {crc[14:0], 1'b0};
              cnt        <= '0;
              state      <= S_CRC;
            end else begin
              sddat0_out <= next_bit;
              sh         <= next_sh;
              crc        <= crc_step(crc, next_bit);
              idx        <= idx_inc;
              if (new_byte && (next_byte != 9'd511)) begin
                inreq  <= 1'b1;
                inaddr <= next_addr;
              end
            end
          end
        end

        S_CRC: begin
          if (sd_fall) begin
            if (cnt == CRC_LAST) begin
              sddat0_out <= 1'b1;
              state      <= S_ENDB;
            end else begin
              sddat0_out <= crc[15];
              crc        <= {crc[14:0], 1'b0};
              cnt        <= cnt_inc;
            end
          end
        end

        S_ENDB: begin
          if (sd_fall) begin
            sddat0_oe  <= 1'b0;
            sddat0_out <= 1'b1;
            cnt        <= '0;
            state      <= S_TOKWAIT;
          end
        end

        S_TOKWAIT: begin
          if (sd_rise) begin
            if (!sddat0_in) begin
              cnt   <= '0;
              state <= S_TOK;
            end else if (cnt_inc > TOK_LIM) begin
              wtimeout <= 1'b1;
              wstatus  <= 3'b111;
              state    <= S_DONE;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        S_TOK: begin
          if (sd_rise) begin
            if (cnt == TOK_BITS) begin
              // This edge carries the token end bit; nothing to capture.
              cnt   <= '0;
              state <= S_BUSY;
            end else begin
              wstatus <= {wstatus[1:0], sddat0_in};
              cnt     <= cnt_inc;
            end
          end
        end

        S_BUSY: begin
          if (sd_rise) begin
            if (sddat0_in) begin
              state <= S_DONE;
            end else if (cnt_inc > BUSY_LIM) begin
              wtimeout <= 1'b1;
              state    <= S_DONE;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        S_DONE: begin
          wdone     <= 1'b1;
          sddat0_oe <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SDWR_STATS_EN
  // Counters step on the same clk edge that raises wdone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ok_cnt   <= 16'h0000;
      wr_fail_cnt <= 16'h0000;
    end else if (state == S_DONE) begin
      if ((wstatus == 3'b010) && !wtimeout) begin
        wr_ok_cnt <= wr_ok_cnt + 16'h0001;
      end else begin
        wr_fail_cnt <= wr_fail_cnt + 16'h0001;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_sd_block_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sd_block_writer
// Purpose  : Scoreboard bench for sd_block_writer with a card model on DAT0
//            and a sector-buffer model on the fetch interface.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_block_writer;

  localparam int PRE    = 2;
  localparam int TOKTO  = 64;
  localparam int BUSYTO = 100;
  localparam int FLEN   = PRE + 1 + 4096 + 16 + 1;

  logic       clk = 1'b0;
  logic       sdclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wstart = 1'b0;
  logic [7:0] inbyte = 8'h00;
  logic       wbusy, wdone, wtimeout, inreq, sddat0_out, sddat0_oe, dir;
  logic [2:0] wstatus;
  logic [8:0] inaddr;
  logic       card_oe = 1'b0;
  logic       card_val = 1'b1;
  logic       dat0;
`ifdef SDWR_STATS_EN
  logic [15:0] wr_ok_cnt, wr_fail_cnt;
  int          ok_model = 0;
  int          fail_model = 0;
`endif

  assign dat0 = sddat0_oe ? sddat0_out : (card_oe ? card_val : 1'b1);

  always #5  clk   = ~clk;
  always #20 sdclk = ~sdclk;

  sd_block_writer #(
    .PRE_CYCLES  (PRE),
    .TOK_TIMEOUT (TOKTO),
    .BUSY_TIMEOUT(BUSYTO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sdclk      (sdclk),
    .wstart     (wstart),
    .wbusy      (wbusy),
    .wdone      (wdone),
    .wstatus    (wstatus),
    .wtimeout   (wtimeout),
    .inreq      (inreq),
    .inaddr     (inaddr),
    .inbyte     (inbyte),
    .sddat0_out (sddat0_out),
    .sddat0_oe  (sddat0_oe),
    .sddat0_in  (dat0),
    .SD_D0_DIR  (dir)
`ifdef SDWR_STATS_EN
    ,
    .wr_ok_cnt  (wr_ok_cnt),
    .wr_fail_cnt(wr_fail_cnt)
`endif
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0] st;
    logic       to;
    int         rises;   // rising edges from DAT0 release to wdone, -1 = don't care
  } res_t;

  logic [7:0]  mem [512];
  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_crc[$];
  logic [8:0]  exp_addr[$];
  res_t        exp_res[$];
  logic        frame[$];
  bit          chk_addr = 1'b1;
  int          addr_cnt = 0;
  int          rises = 0;

  // Card model configuration
  bit          card_armed = 1'b0;
  int          c_mode = 0;          // 0 token+busy, 1 silent, 2 token then hold busy
  logic [2:0]  c_tok = 3'b010;
  int          c_busy = 0;

  // Reference CRC16-CCITT over the sector, bit-serial MSB first.
  function automatic logic [15:0] model_crc();
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int n = 0; n < 512; n++) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ mem[n][k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  function automatic logic get_bit(input int i);
    return (i < frame.size()) ? frame[i] : 1'bx;
  endfunction

  // Sector buffer: data appears for the clk after the fetch strobe.
  initial begin : buffer_model
    logic       r;
    logic [8:0] a;
    forever begin
      @(negedge clk);
      r = inreq;
      a = inaddr;
      @(posedge clk);
      #1;
      inbyte = r ? mem[a] : 8'hxx;
    end
  end

  // Card: starts its token two falling edges after DAT0 is released.
  initial begin : card_model
    forever begin
      @(negedge sddat0_oe);
      if (card_armed && rst_n) begin
        card_armed = 1'b0;
        if (c_mode != 1) begin
          repeat (2) @(negedge sdclk);
          card_oe  = 1'b1;
          card_val = 1'b0;
          for (int b = 2; b >= 0; b--) begin
            @(negedge sdclk);
            card_val = c_tok[b];
          end
          @(negedge sdclk);
          card_val = 1'b1;
          for (int k = 0; k < c_busy; k++) begin
            @(negedge sdclk);
            card_val = 1'b0;
            if (!wbusy) break;
          end
          @(negedge sdclk);
          card_val = 1'b1;
          card_oe  = 1'b0;
        end
      end
    end
  end

  initial begin : frame_sampler
    forever begin
      @(posedge sdclk);
      rises++;
      if (sddat0_oe) frame.push_back(sddat0_out);
    end
  end

  // Frame monitor: a completed DAT0 frame is decoded and scored.
  initial begin : frame_monitor
    logic [7:0]  b;
    logic [15:0] c;
    logic [31:0] pre_v;
    forever begin
      @(negedge sddat0_oe);
      rises = 0;
      if (rst_n) begin
        if (exp_crc.size() == 0) begin
          check("frame_unexpected", frame.size(), 0);
        end else begin
          check("frame_len", frame.size(), FLEN);
          pre_v = 0;
          for (int i = 0; i < PRE; i++) pre_v = {pre_v[30:0], get_bit(i)};
          check("preamble", pre_v, (32'd1 << PRE) - 1);
          check("start_bit", get_bit(PRE), 0);
          for (int n = 0; n < 512; n++) begin
            for (int k = 0; k < 8; k++) b[7-k] = get_bit(PRE + 1 + 8*n + k);
            check($sformatf("data_byte%0d", n), b,
                  (exp_bytes.size() != 0) ? exp_bytes.pop_front() : 8'hxx);
          end
          for (int j = 0; j < 16; j++) c[15-j] = get_bit(PRE + 1 + 4096 + j);
          check("crc16", c, exp_crc.pop_front());
          check("end_bit", get_bit(FLEN - 1), 1);
        end
      end
      frame.delete();
    end
  end

  // Fetch and completion monitor.
  initial begin : result_monitor
    res_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        addr_cnt = 0;
      end else begin
        if (inreq) begin
          addr_cnt++;
          if (chk_addr) begin
            if (exp_addr.size() == 0) check("addr_unexpected", inaddr, 32'h200);
            else check("inaddr", inaddr, exp_addr.pop_front());
          end
        end
        if (wdone) begin
          if (exp_res.size() == 0) begin
            check("wdone_unexpected", wdone, 0);
          end else begin
            r = exp_res.pop_front();
            check("wstatus", wstatus, r.st);
            check("wtimeout", wtimeout, r.to);
            check("oe_at_done", sddat0_oe, 0);
            check("wbusy_at_done", wbusy, 1);
            check("inreq_count", addr_cnt, 512);
            if (r.rises >= 0) check("timeout_edges", rises, r.rises);
`ifdef SDWR_STATS_EN
            if (r.st == 3'b010 && !r.to) ok_model++;
            else fail_model++;
            check("wr_ok_cnt", wr_ok_cnt, ok_model[15:0]);
            check("wr_fail_cnt", wr_fail_cnt, fail_model[15:0]);
`endif
          end
          addr_cnt = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic push_expect(input logic [15:0] crc, input logic [2:0] st,
                             input logic to, input int rcnt);
    res_t r;
    for (int n = 0; n < 512; n++) begin
      exp_addr.push_back(9'(n));
      exp_bytes.push_back(mem[n]);
    end
    exp_crc.push_back(crc);
    r.st = st; r.to = to; r.rises = rcnt;
    exp_res.push_back(r);
  endtask

  task automatic launch();
    @(negedge clk);
    wstart = 1'b1;
    @(negedge clk);
    wstart = 1'b0;
    check("wbusy_rise", wbusy, 1);
  endtask

  task automatic wait_done(input bit poke_in_done);
    bit got = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (wdone) begin
        got = 1'b1;
        break;
      end
    end
    check("wdone_arrived", got, 1);
    if (poke_in_done) wstart = 1'b1;
    @(negedge clk);
    wstart = 1'b0;
    check("wbusy_fall", wbusy, 0);
    repeat (6) @(negedge clk);
    if (poke_in_done) check("wstart_in_wdone_ignored", wbusy, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    bit reached;
    repeat (3) @(negedge clk);
    check("rst_wbusy", wbusy, 0);
    check("rst_wdone", wdone, 0);
    check("rst_wstatus", wstatus, 0);
    check("rst_wtimeout", wtimeout, 0);
    check("rst_inreq", inreq, 0);
    check("rst_inaddr", inaddr, 0);
    check("rst_out", sddat0_out, 1);
    check("rst_oe", sddat0_oe, 0);
    check("rst_dir", dir, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: all-FF sector, token 010, 10 busy periods; wstart poked during wdone.
    for (int n = 0; n < 512; n++) mem[n] = 8'hFF;
    c_mode = 0; c_tok = 3'b010; c_busy = 10; card_armed = 1'b1;
    push_expect(16'h7FA1, 3'b010, 1'b0, -1);
    launch();
    repeat (40) @(negedge clk);
    check("dir_follows_oe", dir, 1);
    wait_done(1'b1);

    // 2: reset in the middle of the data phase (bit 1000).
    for (int n = 0; n < 512; n++) mem[n] = 8'(n);
    chk_addr = 1'b0;
    launch();
    reached = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (frame.size() >= PRE + 1 + 1000) begin
        reached = 1'b1;
        break;
      end
    end
    check("reached_bit1000", reached, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", sddat0_oe, 0);
    check("mid_rst_out", sddat0_out, 1);
    check("mid_rst_wbusy", wbusy, 0);
    check("mid_rst_wdone", wdone, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_addr = 1'b1;
    repeat (300) @(negedge clk);
    check("post_rst_idle", wbusy, 0);

    // 3: ramp sector after reset, card answers CRC error token 101.
    c_mode = 0; c_tok = 3'b101; c_busy = $urandom_range(0, 15); card_armed = 1'b1;
    push_expect(model_crc(), 3'b101, 1'b0, -1);
    launch();
    wait_done(1'b0);

    // 4: random sector, card never answers.
    for (int n = 0; n < 512; n++) mem[n] = 8'($urandom);
    c_mode = 1; card_armed = 1'b1;
    push_expect(model_crc(), 3'b111, 1'b1, TOKTO + 1);
    launch();
    wait_done(1'b0);

    // 5: random sector, token 010 then busy never ends; wstart while busy.
    for (int n = 0; n < 512; n++) mem[n] = 8'($urandom);
    c_mode = 2; c_tok = 3'b010; c_busy = 1000; card_armed = 1'b1;
    push_expect(model_crc(), 3'b010, 1'b1, -1);
    launch();
    repeat ($urandom_range(100, 3000)) @(negedge clk);
    wstart = 1'b1;
    @(negedge clk);
    wstart = 1'b0;
    wait_done(1'b0);

    check("queues_drained", exp_res.size() + exp_crc.size() + exp_addr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
